// File: rtl/gray_pkg.sv
// Shared Gray-code types and helpers for the counter and the FIFO pointer logic.
package gray_pkg;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_t;

  localparam int unsigned GRAY_MAX_WIDTH = 32;

  // Constant-friendly Gray encoder, used for reset values.
  function automatic logic [GRAY_MAX_WIDTH-1:0] bin_to_gray(
    input logic [GRAY_MAX_WIDTH-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray.sv
// Binary to reflected-Gray conversion, purely combinational.
module bin2gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray2bin.sv
// Reflected-Gray to binary conversion; each bit is the XOR of all higher Gray bits.
module gray2bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/gray_counter.sv
// Up/down binary+Gray counter with Gray load, wrap or saturate on overflow,
// and combinational lookahead of the next count.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter cnt_mode_t        MODE    = CNT_WRAP,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_next,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] RST_GRAY =
    WIDTH'(bin_to_gray(GRAY_MAX_WIDTH'(RST_VAL)));

  logic [WIDTH-1:0] load_bin;
  logic             wrap_c;
  logic             sat_c;

  gray2bin #(.WIDTH(WIDTH)) u_load_g2b (
    .gray (load_gray),
    .bin  (load_bin)
  );

  // gray_out is registered from this encoder, so it always tracks bin_out.
  bin2gray #(.WIDTH(WIDTH)) u_next_b2g (
    .bin  (bin_next),
    .gray (gray_next)
  );

  // Next count with priority rst > load > inc&dec > inc > dec > hold.
  always_comb begin : next_count
    bin_next = bin_out;
    wrap_c   = 1'b0;
    sat_c    = 1'b0;
    if (rst) begin
      bin_next = RST_VAL;
    end else if (load) begin
      bin_next = load_bin;
    end else if (inc && !dec) begin
      if (bin_out == CNT_MAX) begin
        if (MODE == CNT_SAT) begin
          sat_c = 1'b1;
        end else begin
          bin_next = '0;
          wrap_c   = 1'b1;
        end
      end else begin
        bin_next = bin_out + CNT_ONE;
      end
    end else if (dec && !inc) begin
      if (bin_out == '0) begin
        if (MODE == CNT_SAT) begin
          sat_c = 1'b1;
        end else begin
          bin_next = CNT_MAX;
          wrap_c   = 1'b1;
        end
      end else begin
        bin_next = bin_out - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin : count_regs
    if (rst) begin
      bin_out  <= RST_VAL;
      gray_out <= RST_GRAY;
      wrap     <= 1'b0;
      sat      <= 1'b0;
    end else begin
      bin_out  <= bin_next;
      gray_out <= gray_next;
      wrap     <= wrap_c;
      sat      <= sat_c;
    end
  end

endmodule

// File: tb/tb_gray_counter.sv
// Randomised bench for gray_counter: a wrapping and a saturating instance share stimulus.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int W     = 4;
  localparam int MAXV  = (1 << W) - 1;
  localparam int RST_S = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inc = 1'b0;
  logic         dec = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_gray = '0;

  logic [W-1:0] bo_w, go_w, bn_w, gn_w;
  logic         wr_w, st_w;
  logic [W-1:0] bo_s, go_s, bn_s, gn_s;
  logic         wr_s, st_s;

  int n_checks = 0;
  int n_errors = 0;

  int m_bin  [2];
  bit m_wrap [2];
  bit m_sat  [2];

  gray_counter #(.WIDTH(W), .MODE(CNT_WRAP), .RST_VAL(4'd0)) u_wrap (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_gray(load_gray),
    .bin_out(bo_w), .gray_out(go_w), .bin_next(bn_w), .gray_next(gn_w),
    .wrap(wr_w), .sat(st_w)
  );

  gray_counter #(.WIDTH(W), .MODE(CNT_SAT), .RST_VAL(4'd5)) u_sat (
    .clk(clk), .rst(rst), .inc(inc), .dec(dec), .load(load), .load_gray(load_gray),
    .bin_out(bo_s), .gray_out(go_s), .bin_next(bn_s), .gray_next(gn_s),
    .wrap(wr_s), .sat(st_s)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int gray_of(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference: integer count with the priority and overflow rules, load decoded by search.
  function automatic void model_next(input int k, input bit r, input bit l, input int lg,
                                     input bit i, input bit d,
                                     output int nb, output bit nw, output bit ns);
    bit is_sat = (k == 1);
    nb = m_bin[k];
    nw = 1'b0;
    ns = 1'b0;
    if (r) begin
      nb = is_sat ? RST_S : 0;
    end else if (l) begin
      for (int b = 0; b <= MAXV; b++) if (gray_of(b) == lg) nb = b;
    end else if (i && !d) begin
      if (m_bin[k] == MAXV) begin
        if (is_sat) ns = 1'b1;
        else begin nb = 0; nw = 1'b1; end
      end else nb = m_bin[k] + 1;
    end else if (d && !i) begin
      if (m_bin[k] == 0) begin
        if (is_sat) ns = 1'b1;
        else begin nb = MAXV; nw = 1'b1; end
      end else nb = m_bin[k] - 1;
    end
  endfunction

  task automatic step(input bit r, input bit l, input logic [W-1:0] lg,
                      input bit i, input bit d);
    int nb0, nb1;
    bit nw0, nw1, ns0, ns1;
    rst = r; load = l; load_gray = lg; inc = i; dec = d;
    model_next(0, r, l, int'(lg), i, d, nb0, nw0, ns0);
    model_next(1, r, l, int'(lg), i, d, nb1, nw1, ns1);
    @(negedge clk);
    check("bin_next_w",  32'(bn_w), 32'(nb0));
    check("gray_next_w", 32'(gn_w), 32'(gray_of(nb0)));
    check("bin_next_s",  32'(bn_s), 32'(nb1));
    check("gray_next_s", 32'(gn_s), 32'(gray_of(nb1)));
    @(posedge clk);
    #1;
    m_bin[0] = nb0; m_wrap[0] = nw0; m_sat[0] = ns0;
    m_bin[1] = nb1; m_wrap[1] = nw1; m_sat[1] = ns1;
    check("bin_out_w",  32'(bo_w), 32'(m_bin[0]));
    check("gray_out_w", 32'(go_w), 32'(gray_of(m_bin[0])));
    check("wrap_w",     32'(wr_w), 32'(m_wrap[0]));
    check("sat_w",      32'(st_w), 32'(m_sat[0]));
    check("bin_out_s",  32'(bo_s), 32'(m_bin[1]));
    check("gray_out_s", 32'(go_s), 32'(gray_of(m_bin[1])));
    check("wrap_s",     32'(wr_s), 32'(m_wrap[1]));
    check("sat_s",      32'(st_s), 32'(m_sat[1]));
  endtask

  initial begin
    logic [W-1:0] prev_g;
    @(posedge clk);
    #1;
    m_bin[0] = 0;     m_wrap[0] = 0; m_sat[0] = 0;
    m_bin[1] = RST_S; m_wrap[1] = 0; m_sat[1] = 0;

    // Reset held with inc asserted.
    step(1, 0, 4'b0000, 1, 0);
    step(1, 0, 4'b0000, 1, 0);
    check("reset_bin_w",  32'(bo_w), 32'd0);
    check("reset_gray_s", 32'(go_s), 32'(4'b0111));

    // Full increment sweep: one Gray bit per step, wrap on the last.
    for (int n = 0; n < 16; n++) begin
      prev_g = go_w;
      step(0, 0, 4'b0000, 1, 0);
      check("hamming_w", 32'($countones(prev_g ^ go_w)), 32'd1);
    end
    check("wrap_pulse_end", 32'(wr_w), 32'd1);
    step(0, 0, 4'b0000, 0, 0);
    check("wrap_cleared", 32'(wr_w), 32'd0);

    // Load 1100 then decrement.
    step(0, 1, 4'b1100, 0, 0);
    check("load_bin", 32'(bo_w), 32'd8);
    step(0, 0, 4'b0000, 0, 1);
    check("dec_gray", 32'(go_w), 32'(4'b0100));

    // Saturation at the top and bottom.
    step(0, 1, 4'b1000, 0, 0);
    step(0, 0, 4'b0000, 1, 0);
    check("sat_top", 32'(st_s), 32'd1);
    step(0, 1, 4'b0000, 0, 0);
    step(0, 0, 4'b0000, 0, 1);
    check("sat_bottom", 32'(bo_s), 32'd0);

    // Priority cases.
    step(0, 0, 4'b0000, 1, 1);
    step(0, 1, 4'b0111, 1, 0);
    check("load_over_inc", 32'(bo_w), 32'd5);
    step(1, 1, 4'b0111, 0, 0);
    check("rst_over_load", 32'(bo_w), 32'd0);

    // Random lookahead and function checks.
    for (int n = 0; n < 400; n++) begin
      step(bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 5) == 0),
           4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning counter width in bits; legal range 2..32.
REQ-002 SHALL have parameter MODE, default CNT_WRAP, meaning overflow behaviour; legal values CNT_WRAP and CNT_SAT.
REQ-003 SHALL have parameter RST_VAL, default 0, meaning binary count loaded on reset.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port inc, input, 1, increment request.
REQ-007 SHALL have port dec, input, 1, decrement request.
REQ-008 SHALL have port load, input, 1, load request.
REQ-009 SHALL have port load_gray, input, WIDTH, Gray-coded value to load.
REQ-010 SHALL have port bin_out, output, WIDTH, registered binary count.
REQ-011 SHALL have port gray_out, output, WIDTH, registered Gray count, equal to bin_out ^ (bin_out >> 1) every cycle.
REQ-012 SHALL have port bin_next, output, WIDTH, combinational value bin_out will take at the next edge.
REQ-013 SHALL have port gray_next, output, WIDTH, Gray encoding of bin_next, combinational.
REQ-014 SHALL have port wrap, output, 1, registered one-cycle pulse on count wrap.
REQ-015 SHALL have port sat, output, 1, registered one-cycle pulse on a blocked step in CNT_SAT mode.

Function
REQ-016 SHALL apply per-cycle priority rst > load > (inc & dec) > inc > dec > hold.
REQ-017 SHALL, on load, convert load_gray to binary and register it, so bin_out and gray_out update one cycle after load (gray_out == load_gray).
REQ-018 SHALL, on inc and dec together without load, hold the count, with wrap = 0 and sat = 0.
REQ-019 SHALL, on inc alone, set bin_next = bin_out + 1 modulo 2^WIDTH in CNT_WRAP mode.
REQ-020 SHALL, on dec alone, set bin_next = bin_out - 1 modulo 2^WIDTH in CNT_WRAP mode.
REQ-021 SHALL, in CNT_WRAP mode, pulse wrap on the cycle after the step for 2^WIDTH-1 -> 0 on inc or 0 -> 2^WIDTH-1 on dec; sat stays 0.
REQ-022 SHALL, in CNT_SAT mode, hold the count at 2^WIDTH-1 on inc and at 0 on dec, and pulse sat on the cycle after; wrap stays 0.
REQ-023 SHALL have every non-load, non-reset update change gray_out in exactly one bit, or in zero bits on hold or saturation.
REQ-024 SHALL keep bin_next and gray_next glitch-free functions of current state and inputs, with no added register stage.
REQ-025 SHALL never assert wrap and sat in the same cycle; both are 0 on load and hold cycles.

Reset
REQ-026 SHALL, when rst is high at a rising edge, set bin_out = RST_VAL, gray_out = Gray(RST_VAL), wrap = 0 and sat = 0, overriding any concurrent inc, dec or load.
REQ-027 SHALL drive bin_next = RST_VAL and gray_next = Gray(RST_VAL) combinationally while rst is high.
REQ-028 SHALL resume counting from RST_VAL on the first edge after rst deasserts, so reset asserted mid-count abandons the count.

Structure
REQ-029 SHALL place typedef enum cnt_mode_t {CNT_WRAP, CNT_SAT} in shared package gray_pkg, which the FIFO pointer logic also imports.
REQ-030 SHALL instantiate the existing gray2bin sub-module for the load path and bin2gray for gray_out and gray_next; no other sub-modules.
REQ-031 SHALL keep all registers in one clocked process, with next-state logic in a combinational process.

Verification (WIDTH=4)
REQ-032 SHALL cover reset: rst high 2 cycles with inc=1 -> bin_out=0, gray_out=0000, wrap=0, sat=0.
REQ-033 SHALL cover wrap: CNT_WRAP, inc held 16 cycles from 0 -> gray_out sequence 0000, 0001, 0011, 0010, 0110, ... 1000, then 0000 with wrap=1 for exactly one cycle; each step has Hamming distance 1.
REQ-034 SHALL cover load then decrement: load_gray=1100 -> next cycle bin_out=8, gray_out=1100; then dec -> bin_out=7, gray_out=0100.
REQ-035 SHALL cover saturation: CNT_SAT at 15, inc -> bin_out stays 15 and sat=1 one cycle; at 0, dec -> bin_out stays 0 and sat=1.
REQ-036 SHALL cover priority: inc=dec=1 -> hold with no pulses; load=1 with inc=1 and load_gray=0111 -> bin_out=5; rst=1 with load=1 -> bin_out=0.
REQ-037 SHALL cover lookahead: every cycle, bin_next equals the following cycle's bin_out and gray_next equals the following cycle's gray_out, checked under random inc, dec and load.
